image_control: RTL and testbench

IMAGE_CONTROL -- requirements
Module: image_control

---
 rtl/image_control.sv | 226 ++++++++++++++++++++++
 tb/tb_image_control.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_control.sv
// ============================================================================
// image_control
// ----------------------------------------------------------------------------
// Purpose:
//   Buffers an incoming raster stream into four line buffers and, once three
//   complete lines are available, streams out 3x3 pixel windows (one per
//   column of the oldest line) to a downstream convolution datapath.
//   A one-cycle interrupt marks each line that has been fully consumed, so
//   the producer knows a line buffer has been freed.
//
// Parameters:
//   IMG_WIDTH           pixels per image line (4..4096)
//
// Ports:
//   i_clk               single clock, all logic on the rising edge
//   i_rst               synchronous active-high reset
//   i_pixel_data        incoming raster pixel (8 bits)
//   i_pixel_data_valid  qualifies i_pixel_data, one pixel per asserted cycle
//   o_pixel_data        3x3 window, byte 8*(3*row+col) = line row, column col
//   o_pixel_data_valid  qualifies o_pixel_data (one cycle after the read)
//   o_intr              one-cycle pulse when a line buffer has been freed
//   o_overflow          sticky flag, set after a write was dropped because
//                       all four line buffers were full (optional port)
//
// Configuration:
//   IMAGE_CONTROL_OVF_DET_EN  when defined, adds the o_overflow port. When
//                             undefined, full-buffer writes are still dropped,
//                             just without any indication.
// ============================================================================
module image_control #(
    parameter int IMG_WIDTH = 512
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_pixel_data,
    input  logic        i_pixel_data_valid,
    output logic [71:0] o_pixel_data,
    output logic        o_pixel_data_valid,
    output logic        o_intr
`ifdef IMAGE_CONTROL_OVF_DET_EN
    ,
    output logic        o_overflow
`endif
);

    localparam int COL_W  = $clog2(IMG_WIDTH);
    localparam int FILL_W = $clog2(4 * IMG_WIDTH + 1);

    localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(IMG_WIDTH - 1);
    localparam logic [FILL_W-1:0] FULL_LEVEL = FILL_W'(4 * IMG_WIDTH);
    localparam logic [FILL_W-1:0] READ_LEVEL = FILL_W'(3 * IMG_WIDTH);

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    // Line storage; contents are deliberately not reset.
    logic [7:0] line_mem [4][IMG_WIDTH];

    logic [1:0]        wr_buf;
    logic [COL_W-1:0]  wr_col;
    logic [1:0]        rd_buf;
    logic [COL_W-1:0]  rd_col;
    logic [FILL_W-1:0] fill;

    state_t state;
    state_t next_state;

    logic        read_issue;
    logic        write_accept;
    logic [71:0] window;

    logic [1:0]       line_sel;
    logic [COL_W:0]   col_sum;
    logic [COL_W-1:0] col_sel;

    // A write is only refused when every buffer slot is occupied and no read
    // frees a slot in the same cycle; a concurrent read makes room for it.
    assign write_accept = i_pixel_data_valid &&
                          ((fill != FULL_LEVEL) || read_issue);

    // Read FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Read FSM next state. Once three complete lines are buffered, one read
    // is issued every cycle until the last column of the current line has
    // been read; the FSM then drops back to IDLE for at least one cycle and
    // re-evaluates the fill level before starting the next line.
    always_comb begin
        next_state = state;
        read_issue = 1'b0;
        case (state)
            IDLE: begin
                if (fill >= READ_LEVEL) begin
                    next_state = READ;
                end
            end
            READ: begin
                read_issue = 1'b1;
                if (rd_col == LAST_COL) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Write pointer: column within the current line, and which of the four
    // buffers that line lives in. Advances only on accepted writes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_buf <= 2'd0;
            wr_col <= '0;
        end else if (write_accept) begin
            if (wr_col == LAST_COL) begin
                wr_col <= '0;
                wr_buf <= wr_buf + 2'd1;
            end else begin
                wr_col <= wr_col + COL_W'(1);
            end
        end
    end

    // Read pointer: column of the oldest line being turned into windows.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_buf <= 2'd0;
            rd_col <= '0;
        end else if (read_issue) begin
            if (rd_col == LAST_COL) begin
                rd_col <= '0;
                rd_buf <= rd_buf + 2'd1;
            end else begin
                rd_col <= rd_col + COL_W'(1);
            end
        end
    end

    // Fill counts buffered pixels not yet consumed by a read; a write and a
    // read in the same cycle cancel out.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fill <= '0;
        end else begin
            case ({write_accept, read_issue})
                2'b10:   fill <= fill + FILL_W'(1);
                2'b01:   fill <= fill - FILL_W'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Line buffer write port. Reset wins over a coincident write so that a
    // reset cannot leave a stray pixel behind at the old write position.
    always_ff @(posedge i_clk) begin
        if (write_accept && !i_rst) begin
            line_mem[wr_buf][wr_col] <= i_pixel_data;
        end
    end

    // Window assembly: rows come from the three consecutive buffers starting
    // at rd_buf, columns from rd_col onward. Columns past the right edge are
    // clamped to the last pixel, which replicates the border. The read is
    // combinational so a same-cycle write to the same slot (only possible
    // when the buffer is full) returns the old pixel.
    always_comb begin
        window   = '0;
        line_sel = 2'd0;
        col_sum  = '0;
        col_sel  = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                line_sel = rd_buf + 2'(r);
                col_sum  = {1'b0, rd_col} + (COL_W + 1)'(c);
                if (col_sum > {1'b0, LAST_COL}) begin
                    col_sel = LAST_COL;
                end else begin
                    col_sel = col_sum[COL_W-1:0];
                end
                window[8*(3*r+c) +: 8] = line_mem[line_sel][col_sel];
            end
        end
    end

    // Output register. The window is captured only when a read issues, so
    // o_pixel_data holds its last value between lines. The interrupt rides
    // along with the window for the line's last column.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pixel_data       <= '0;
            o_pixel_data_valid <= 1'b0;
            o_intr             <= 1'b0;
        end else begin
            o_pixel_data_valid <= read_issue;
            o_intr             <= read_issue && (rd_col == LAST_COL);
            if (read_issue) begin
                o_pixel_data <= window;
            end
        end
    end

`ifdef IMAGE_CONTROL_OVF_DET_EN
    logic write_drop;

    assign write_drop = i_pixel_data_valid && (fill == FULL_LEVEL) && !read_issue;

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_overflow <= 1'b0;
        end else if (write_drop) begin
            o_overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_image_control.sv
// ============================================================================
// tb_image_control
// ----------------------------------------------------------------------------
// Self-checking bench for image_control with IMG_WIDTH = 8. A reference model
// tracks the stream as linear write/read positions over a flat pixel store
// and predicts every output each cycle; a directed vector table and a few
// hand-written sequences pin down threshold, window contents, line handoff,
// mid-line reset and overflow behaviour. Randomized traffic follows.
// ============================================================================
module tb_image_control;

    localparam int W     = 8;
    localparam int DEPTH = 4 * W;
    localparam int NVEC  = 36;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = 8'd0;
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid;
    logic        o_intr;
`ifdef IMAGE_CONTROL_OVF_DET_EN
    logic        o_overflow;
`endif

    always #5 clk = ~clk;

    image_control #(.IMG_WIDTH(W)) dut (
        .i_clk              (clk),
        .i_rst              (i_rst),
        .i_pixel_data       (wr_data),
        .i_pixel_data_valid (wr_valid),
        .o_pixel_data       (o_pixel_data),
        .o_pixel_data_valid (o_pixel_data_valid),
        .o_intr             (o_intr)
`ifdef IMAGE_CONTROL_OVF_DET_EN
        ,
        .o_overflow         (o_overflow)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: linear positions into a 4-line circular store.
    int          m_fill;
    int          m_wptr;
    int          m_rptr;
    bit          m_reading;
    logic [7:0]  m_mem [DEPTH];
    logic [71:0] m_data;
    logic        m_valid;
    logic        m_intr;
    logic        m_ovf;

    typedef struct {
        logic        rst;
        logic        wr;
        logic [7:0]  px;
        logic        exp_valid;
        logic        exp_intr;
        logic [71:0] exp_data;
    } vec_t;

    vec_t vecs [NVEC];

    // Test pattern: pixel value = line*16 + column for stream index k.
    function automatic logic [7:0] pix(input int k);
        return 8'((k / W) * 16 + (k % W));
    endfunction

    // Expected window for the pattern above, built straight from the
    // pattern formula (independent of any buffer bookkeeping).
    function automatic logic [71:0] ref_window(input int line0, input int col);
        logic [71:0] w;
        int cc;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                cc = (col + c > W - 1) ? W - 1 : col + c;
                w[8*(3*r+c) +: 8] = 8'((line0 + r) * 16 + cc);
            end
        end
        return w;
    endfunction

    task automatic check_value(input string name, input logic [71:0] actual,
                               input logic [71:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_fill    = 0;
        m_wptr    = 0;
        m_rptr    = 0;
        m_reading = 1'b0;
        m_data    = '0;
        m_valid   = 1'b0;
        m_intr    = 1'b0;
        m_ovf     = 1'b0;
    endtask

    // Advance the model by one clock given this cycle's inputs; afterwards
    // the m_* outputs are what the DUT should show after the edge.
    task automatic model_step(input logic rst, input logic wr, input logic [7:0] px);
        int  line;
        int  col;
        int  cc;
        bit  rd;
        bit  accept;
        bit  next_reading;
        if (rst) begin
            model_reset();
        end else begin
            rd   = m_reading;
            line = m_rptr / W;
            col  = m_rptr % W;
            if (rd) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        cc = (col + c > W - 1) ? W - 1 : col + c;
                        m_data[8*(3*r+c) +: 8] = m_mem[((line + r) % 4) * W + cc];
                    end
                end
                m_valid = 1'b1;
                m_intr  = (col == W - 1);
            end else begin
                m_valid = 1'b0;
                m_intr  = 1'b0;
            end
            accept = wr && ((m_fill < DEPTH) || rd);
            if (wr && !accept) m_ovf = 1'b1;
            if (accept) begin
                m_mem[m_wptr] = px;
                m_wptr = (m_wptr + 1) % DEPTH;
            end
            next_reading = rd ? (col != W - 1) : (m_fill >= 3 * W);
            m_fill = m_fill + int'(accept) - int'(rd);
            if (rd) m_rptr = (m_rptr + 1) % DEPTH;
            m_reading = next_reading;
        end
    endtask

    task automatic check_output();
        check_value("valid", 72'(o_pixel_data_valid), 72'(m_valid));
        check_value("intr", 72'(o_intr), 72'(m_intr));
        check_value("data", o_pixel_data, m_data);
        check_value("fill", 72'(dut.fill), 72'(m_fill));
`ifdef IMAGE_CONTROL_OVF_DET_EN
        check_value("overflow", 72'(o_overflow), 72'(m_ovf));
`endif
    endtask

    // Drive one cycle of inputs, step the model, sample #1 after the edge.
    task automatic apply_stimulus(input logic rst, input logic wr, input logic [7:0] px);
        i_rst    = rst;
        wr_valid = wr;
        wr_data  = px;
        model_step(rst, wr, px);
        @(posedge clk);
        #1;
        check_output();
    endtask

    initial begin
        int n;
        int intr_count;
        int seen;
        int early;
        int latency;
        int max_fill;
        int rate;
        logic rst_r;
        logic wr_r;

        model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'd0;

        // Directed table: 24 pattern writes then idle. Output for the read of
        // column i-25 appears at row i; first window and the clamped rd_col=6
        // window are spelled out as literal bytes.
        for (int i = 0; i < NVEC; i++) begin
            vecs[i].rst       = 1'b0;
            vecs[i].wr        = (i < 24);
            vecs[i].px        = (i < 24) ? pix(i) : 8'd0;
            vecs[i].exp_valid = (i >= 25) && (i <= 32);
            vecs[i].exp_intr  = (i == 32);
            if (i < 25)       vecs[i].exp_data = '0;
            else if (i <= 32) vecs[i].exp_data = ref_window(0, i - 25);
            else              vecs[i].exp_data = ref_window(0, W - 1);
        end
        vecs[25].exp_data = 72'h22_21_20_12_11_10_02_01_00;
        vecs[31].exp_data = 72'h27_27_26_17_17_16_07_07_06;

        $display("[TB] reset");
        apply_stimulus(1'b1, 1'b0, 8'd0);
        apply_stimulus(1'b1, 1'b0, 8'd0);
        check_value("reset_valid", 72'(o_pixel_data_valid), 72'd0);
        check_value("reset_intr", 72'(o_intr), 72'd0);
        check_value("reset_data", o_pixel_data, 72'd0);
        check_value("reset_fill", 72'(dut.fill), 72'd0);

        $display("[TB] vector table: threshold and window contents");
        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].wr, vecs[i].px);
            check_value($sformatf("vec%0d_valid", i), 72'(o_pixel_data_valid), 72'(vecs[i].exp_valid));
            check_value($sformatf("vec%0d_intr", i), 72'(o_intr), 72'(vecs[i].exp_intr));
            check_value($sformatf("vec%0d_data", i), o_pixel_data, vecs[i].exp_data);
        end

        $display("[TB] line handoff with continuous writes");
        apply_stimulus(1'b1, 1'b0, 8'd0);
        n = 0;
        intr_count = 0;
        for (int k = 0; k < 62; k++) begin
            apply_stimulus(1'b0, k < 32, (k < 32) ? pix(k) : 8'd0);
            if (o_intr) intr_count++;
            if (o_pixel_data_valid) begin
                check_value($sformatf("handoff_win%0d", n), o_pixel_data, ref_window(n / W, n % W));
                check_value($sformatf("handoff_intr%0d", n), 72'(o_intr), 72'(n % W == W - 1));
                if (n < 7) check_value($sformatf("handoff_fill%0d", n), 72'(dut.fill), 72'd25);
                n++;
            end else begin
                check_value("handoff_intr_idle", 72'(o_intr), 72'd0);
            end
        end
        check_value("handoff_outputs", 72'(n), 72'd16);
        check_value("handoff_intr_count", 72'(intr_count), 72'd2);

        $display("[TB] mid-line reset");
        apply_stimulus(1'b1, 1'b0, 8'd0);
        for (int k = 0; k < 24; k++) apply_stimulus(1'b0, 1'b1, pix(k));
        seen = 0;
        for (int t = 0; t < 20 && seen < 3; t++) begin
            apply_stimulus(1'b0, 1'b0, 8'd0);
            if (o_pixel_data_valid) seen++;
        end
        check_value("midreset_reach_col3", 72'(seen), 72'd3);
        apply_stimulus(1'b1, 1'b1, 8'hAA);
        check_value("midreset_valid", 72'(o_pixel_data_valid), 72'd0);
        check_value("midreset_intr", 72'(o_intr), 72'd0);
        check_value("midreset_data", o_pixel_data, 72'd0);
        check_value("midreset_fill", 72'(dut.fill), 72'd0);
        early = 0;
        for (int k = 0; k < 23; k++) begin
            apply_stimulus(1'b0, 1'b1, 8'(8'h80 + k));
            if (o_pixel_data_valid || o_intr) early++;
        end
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(1'b0, 1'b0, 8'd0);
            if (o_pixel_data_valid || o_intr) early++;
        end
        check_value("midreset_no_early_output", 72'(early), 72'd0);
        apply_stimulus(1'b0, 1'b1, 8'h97);
        latency = -1;
        for (int t = 1; t <= 5 && latency < 0; t++) begin
            apply_stimulus(1'b0, 1'b0, 8'd0);
            if (o_pixel_data_valid) latency = t;
        end
        check_value("midreset_first_valid_latency", 72'(latency), 72'd2);

        $display("[TB] sustained writes into a full store");
        apply_stimulus(1'b1, 1'b0, 8'd0);
        max_fill = 0;
        for (int k = 0; k < 200; k++) begin
            apply_stimulus(1'b0, 1'b1, pix(k));
            if (int'(dut.fill) > max_fill) max_fill = int'(dut.fill);
        end
        check_value("overflow_fill_bounded", 72'(max_fill <= DEPTH), 72'd1);
        check_value("overflow_fill_reached_full", 72'(max_fill), 72'(DEPTH));
`ifdef IMAGE_CONTROL_OVF_DET_EN
        check_value("overflow_sticky", 72'(o_overflow), 72'd1);
        for (int k = 0; k < 40; k++) apply_stimulus(1'b0, 1'b0, 8'd0);
        check_value("overflow_still_set", 72'(o_overflow), 72'd1);
        apply_stimulus(1'b1, 1'b0, 8'd0);
        check_value("overflow_cleared", 72'(o_overflow), 72'd0);
`endif

        $display("[TB] randomized traffic");
        apply_stimulus(1'b1, 1'b0, 8'd0);
        for (int seg = 0; seg < 15; seg++) begin
            case ($urandom_range(0, 3))
                0:       rate = 30;
                1:       rate = 70;
                2:       rate = 95;
                default: rate = 100;
            endcase
            for (int k = 0; k < 200; k++) begin
                rst_r = ($urandom_range(0, 499) == 0);
                wr_r  = ($urandom_range(0, 99) < rate);
                apply_stimulus(rst_r, wr_r, 8'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
